reg_mem_bank: RTL and testbench
===============================

# reg_mem_bank

Parametrised register-memory bank for the lab top level. It has one write port and two independent read ports with registered outputs, plus a write-first bypass. A sequenced clear engine zeroes the array one entry per cycle, and a counter tracks accepted writes. A seven-segment decode of read port A drives the board display directly, so the top only wires switches to ports.

## Interface
Parameters:
- ADDR_WIDTH, 2: address width; DEPTH = 2**ADDR_WIDTH entries
- DATA_WIDTH, 4: entry width, ≥ 4
- CNT_WIDTH, 8: width of the accepted-write counter

Ports:
- clk_2  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- clr  in  1  clear request, sampled each edge
- wr_en  in  1  write request
- waddr  in  ADDR_WIDTH  write address
- wdata  in  DATA_WIDTH  write data
- raddr_a, raddr_b  in  ADDR_WIDTH  read addresses
- rdata_a, rdata_b  out  DATA_WIDTH  registered read data
- busy  out  1  high while the clear engine runs
- wr_reject  out  1  registered pulse: a write request was dropped
- wr_count  out  CNT_WIDTH  number of accepted writes, wraps
- seg  out  8  seven-segment pattern of rdata_a[3:0], bit 7 always 0

## Operation
- Reset (reset_n low, takes effect immediately):
  - all entries become 0
  - rdata_a, rdata_b, wr_count = 0
  - busy = 0, wr_reject = 0
  - seg = pattern of 0 (8'b00111111)
  - FSM goes to IDLE, clear pointer = 0
- FSM states: IDLE, CLEAR.
- In IDLE:
  - clr=1: go to CLEAR, ptr=0, wr_count=0. A wr_en in the same cycle is dropped and wr_reject pulses.
  - clr=0, wr_en=1: write mem[waddr]=wdata and increment wr_count modulo 2**CNT_WIDTH.
- In CLEAR, each edge:
  - mem[ptr]=0, ptr++.
  - When ptr==DEPTH-1, zero that entry and return to IDLE.
  - clr is ignored.
  - wr_en is dropped and wr_reject pulses.
- busy = (state==CLEAR), decoded from the state register.
- Reads: each edge, rdata_x takes mem[raddr_x].
  - Write-first bypass: if an accepted write targets raddr_x in the same cycle, rdata_x takes wdata.
  - If a clear step zeroes raddr_x in the same cycle, rdata_x takes 0.
  - Both ports may read the same address.
- seg is a combinational decode of rdata_a[3:0] to the 16 hex patterns (0–F). DATA_WIDTH bits above 3 are not displayed.

## Timing
- Read latency: 1 cycle. The address presented before edge k gives data valid after edge k.
- Write: the entry is updated at the accepting edge. A read at the next edge sees it; a read at the same edge also sees it through the bypass.
- Clear:
  - clr sampled at edge k sets busy from k on.
  - Entries 0..DEPTH-1 are zeroed at edges k+1..k+DEPTH.
  - busy falls after edge k+DEPTH.
  - Writes are accepted again from edge k+DEPTH+1.
- wr_reject is high for exactly the cycle after each dropped request.
- reset_n asserted mid-clear aborts the sweep; the reset values above apply at once. The first edge after release is a normal IDLE cycle.

## Structure
- Shared package mem_pkg holds:
  - the state enum (IDLE, CLEAR)
  - the 16 seven-segment constants NUM_0..NUM_F and VOID
  - a function hex_to_seg(logic [3:0]) returning logic [7:0]
- One sub-module, seg7_decoder, wraps hex_to_seg. Later display-driving blocks reuse it.
- The memory array, FSM, pointer, counter and read registers all live in reg_mem_bank.

## Test plan
- Reset release, then read all addresses on both ports: rdata = 0, seg = 8'b00111111, wr_count = 0, busy = 0.
- Write mem[2]=4'hA with raddr_a=2 in the same cycle: rdata_a = A after that edge (bypass). seg = 8'b01110111, wr_count = 1.
- Fill all 4 entries with 5, 6, 7, 8, then pulse clr:
  - busy is high for exactly 4 cycles.
  - raddr_b=3 reads 8 until the 4th clear edge, then 0.
  - wr_count = 0.
- Assert wr_en together with clr, and again during CLEAR:
  - no entry changes to wdata.
  - wr_reject pulses once per request.
  - wr_count stays 0.
- Drop reset_n for a partial cycle two edges into a clear sweep: all outputs go to reset values immediately. A write to addr 1 in the first cycle after release is accepted, with wr_count = 1.
- Write 256 times with CNT_WIDTH=8: wr_count wraps to 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and seven-segment constants for the register-memory bank.
// Segment order is {dp, g, f, e, d, c, b, a}, active high; dp is never lit.
package mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam logic [7:0] NUM_0 = 8'b0011_1111;
    localparam logic [7:0] NUM_1 = 8'b0000_0110;
    localparam logic [7:0] NUM_2 = 8'b0101_1011;
    localparam logic [7:0] NUM_3 = 8'b0100_1111;
    localparam logic [7:0] NUM_4 = 8'b0110_0110;
    localparam logic [7:0] NUM_5 = 8'b0110_1101;
    localparam logic [7:0] NUM_6 = 8'b0111_1101;
    localparam logic [7:0] NUM_7 = 8'b0000_0111;
    localparam logic [7:0] NUM_8 = 8'b0111_1111;
    localparam logic [7:0] NUM_9 = 8'b0110_1111;
    localparam logic [7:0] NUM_A = 8'b0111_0111;
    localparam logic [7:0] NUM_B = 8'b0111_1100;
    localparam logic [7:0] NUM_C = 8'b0011_1001;
    localparam logic [7:0] NUM_D = 8'b0101_1110;
    localparam logic [7:0] NUM_E = 8'b0111_1001;
    localparam logic [7:0] NUM_F = 8'b0111_0001;
    localparam logic [7:0] VOID  = 8'b0000_0000;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] pat;
        case (hex)
            4'h0: pat = NUM_0;
            4'h1: pat = NUM_1;
            4'h2: pat = NUM_2;
            4'h3: pat = NUM_3;
            4'h4: pat = NUM_4;
            4'h5: pat = NUM_5;
            4'h6: pat = NUM_6;
            4'h7: pat = NUM_7;
            4'h8: pat = NUM_8;
            4'h9: pat = NUM_9;
            4'hA: pat = NUM_A;
            4'hB: pat = NUM_B;
            4'hC: pat = NUM_C;
            4'hD: pat = NUM_D;
            4'hE: pat = NUM_E;
            4'hF: pat = NUM_F;
            default: pat = VOID;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/reg_mem_bank_if.sv
// Bus bundle for reg_mem_bank: write port, two read ports, clear and status.
interface reg_mem_bank_if #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
);
    logic                  clr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] raddr_a;
    logic [ADDR_WIDTH-1:0] raddr_b;
    logic [DATA_WIDTH-1:0] rdata_a;
    logic [DATA_WIDTH-1:0] rdata_b;
    logic                  busy;
    logic                  wr_reject;
    logic [CNT_WIDTH-1:0]  wr_count;
    logic [7:0]            seg;

    modport master (
        output clr, wr_en, waddr, wdata, raddr_a, raddr_b,
        input  rdata_a, rdata_b, busy, wr_reject, wr_count, seg
    );

    modport slave (
        input  clr, wr_en, waddr, wdata, raddr_a, raddr_b,
        output rdata_a, rdata_b, busy, wr_reject, wr_count, seg
    );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational hex digit to seven-segment pattern, shared by display blocks.
module seg7_decoder
    import mem_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/reg_mem_bank.sv
// Register-memory bank: one write port, two registered read ports with
// write-first bypass, sequenced clear engine and accepted-write counter.
module reg_mem_bank
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input logic           clk_2,
    input logic           reset_n,
    reg_mem_bank_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rda_q, rda_d;
    logic [DATA_WIDTH-1:0] rdb_q, rdb_d;
    logic                  rej_q, rej_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  wr_accept;
    logic [7:0]            seg_w;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        mem_d     = mem_q;
        wr_accept = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end else if (bus.wr_en) begin
                    wr_accept          = 1'b1;
                    mem_d[bus.waddr]   = bus.wdata;
                    cnt_d              = cnt_q + CNT_WIDTH'(1);
                end
            end
            CLEAR: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                end
            end
        endcase
        rej_d = bus.wr_en && !wr_accept;
        // Reading the next-state array gives write-first bypass and
        // same-cycle clear visibility without separate compare logic.
        rda_d = mem_d[bus.raddr_a];
        rdb_d = mem_d[bus.raddr_b];
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rda_q   <= '0;
            rdb_q   <= '0;
            rej_q   <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rda_q   <= rda_d;
            rdb_q   <= rdb_d;
            rej_q   <= rej_d;
            mem_q   <= mem_d;
        end
    end

    seg7_decoder u_seg7 (
        .hex (rda_q[3:0]),
        .seg (seg_w)
    );

    assign bus.rdata_a   = rda_q;
    assign bus.rdata_b   = rdb_q;
    assign bus.busy      = (state_q == CLEAR);
    assign bus.wr_reject = rej_q;
    assign bus.wr_count  = cnt_q;
    assign bus.seg       = seg_w;

endmodule

// File: tb/tb_reg_mem_bank.sv
// Scoreboard bench for reg_mem_bank: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_reg_mem_bank;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 4;
    localparam int unsigned CW = 8;

    typedef enum int unsigned {K_RDA, K_RDB, K_SEG, K_BUSY, K_REJ, K_CNT} kind_e;
    typedef struct {
        int unsigned cyc;
        kind_e       kind;
        logic [31:0] val;
        string       nm;
    } exp_t;

    logic        clk_2   = 1'b0;
    logic        reset_n = 1'b0;
    int unsigned cyc     = 0;
    int unsigned errors  = 0;
    int unsigned checks  = 0;
    exp_t        sb[$];

    reg_mem_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    reg_mem_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk_2 = ~clk_2;
    always @(posedge clk_2) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input kind_e k);
        case (k)
            K_RDA:   return 32'(bus.rdata_a);
            K_RDB:   return 32'(bus.rdata_b);
            K_SEG:   return 32'(bus.seg);
            K_BUSY:  return 32'(bus.busy);
            K_REJ:   return 32'(bus.wr_reject);
            default: return 32'(bus.wr_count);
        endcase
    endfunction

    // Monitor: compare every expectation scheduled for the current cycle.
    always @(negedge clk_2) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.nm, e.cyc, cyc);
            end else begin
                a = actual(e.kind);
                if (a !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got %0h expected %0h", e.nm, cyc, a, e.val);
                end
            end
        end
    end

    task automatic drive(input logic c, input logic w, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb);
        @(negedge clk_2);
        #1;
        bus.clr     = c;
        bus.wr_en   = w;
        bus.waddr   = wa;
        bus.wdata   = wd;
        bus.raddr_a = ra;
        bus.raddr_b = rb;
    endtask

    task automatic exp_next(input kind_e k, input logic [31:0] v, input string nm);
        sb.push_back('{cyc + 1, k, v, nm});
    endtask

    task automatic exp_now(input kind_e k, input logic [31:0] v, input string nm);
        sb.push_back('{cyc, k, v, nm});
    endtask

    initial begin
        bus.clr = 1'b0; bus.wr_en = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.raddr_a = '0; bus.raddr_b = '0;
        repeat (2) @(negedge clk_2);
        #1 reset_n = 1'b1;

        // Reset state on every address of both ports.
        for (int a = 0; a < 4; a++) begin
            drive(1'b0, 1'b0, 2'd0, 4'h0, AW'(a), AW'(3 - a));
            exp_next(K_RDA, 0, "rst_rda");
            exp_next(K_RDB, 0, "rst_rdb");
            exp_next(K_SEG, 32'h3F, "rst_seg");
            exp_next(K_CNT, 0, "rst_cnt");
            exp_next(K_BUSY, 0, "rst_busy");
            exp_next(K_REJ, 0, "rst_rej");
        end

        // Write with same-cycle read: bypass.
        drive(1'b0, 1'b1, 2'd2, 4'hA, 2'd2, 2'd2);
        exp_next(K_RDA, 32'hA, "bypass_a");
        exp_next(K_RDB, 32'hA, "bypass_b");
        exp_next(K_SEG, 32'h77, "seg_a");
        exp_next(K_CNT, 1, "cnt_1");

        // Fill 5,6,7,8 then read back.
        drive(1'b0, 1'b1, 2'd0, 4'h5, 2'd0, 2'd0); exp_next(K_RDA, 5, "fill0"); exp_next(K_CNT, 2, "cnt_2");
        drive(1'b0, 1'b1, 2'd1, 4'h6, 2'd1, 2'd0); exp_next(K_RDA, 6, "fill1"); exp_next(K_RDB, 5, "fill1_b");
        drive(1'b0, 1'b1, 2'd2, 4'h7, 2'd2, 2'd1); exp_next(K_RDA, 7, "fill2"); exp_next(K_CNT, 4, "cnt_4");
        drive(1'b0, 1'b1, 2'd3, 4'h8, 2'd3, 2'd2); exp_next(K_RDA, 8, "fill3"); exp_next(K_CNT, 5, "cnt_5");
        drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd1); exp_next(K_RDA, 5, "rd0"); exp_next(K_RDB, 6, "rd1");
        drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd2, 2'd3); exp_next(K_RDA, 7, "rd2"); exp_next(K_RDB, 8, "rd3");

        // Clear sweep: busy for 4 cycles, entry 3 zeroed at the 4th edge.
        drive(1'b1, 1'b0, 2'd0, 4'h0, 2'd0, 2'd3);
        exp_next(K_BUSY, 1, "clr_busy0"); exp_next(K_CNT, 0, "clr_cnt");
        exp_next(K_RDA, 5, "clr_rda0"); exp_next(K_RDB, 8, "clr_rdb0");
        drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd3);
        exp_next(K_BUSY, 1, "clr_busy1"); exp_next(K_RDA, 0, "clr_zero0"); exp_next(K_RDB, 8, "clr_rdb1");
        drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 2'd3);
        exp_next(K_BUSY, 1, "clr_busy2"); exp_next(K_RDA, 0, "clr_zero1"); exp_next(K_RDB, 8, "clr_rdb2");
        drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd2, 2'd3);
        exp_next(K_BUSY, 1, "clr_busy3"); exp_next(K_RDB, 8, "clr_rdb3"); exp_next(K_CNT, 0, "clr_cnt3");
        drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd2, 2'd3);
        exp_next(K_BUSY, 0, "clr_done"); exp_next(K_RDB, 0, "clr_zero3"); exp_next(K_RDA, 0, "clr_zero2");

        // Writes dropped alongside clr and during the sweep.
        drive(1'b0, 1'b1, 2'd1, 4'h3, 2'd1, 2'd1); exp_next(K_CNT, 1, "pre_cnt"); exp_next(K_REJ, 0, "pre_rej");
        drive(1'b1, 1'b1, 2'd1, 4'hF, 2'd1, 2'd1);
        exp_next(K_REJ, 1, "rej_with_clr"); exp_next(K_CNT, 0, "rej_cnt0");
        exp_next(K_BUSY, 1, "rej_busy"); exp_next(K_RDA, 3, "rej_nobypass");
        drive(1'b0, 1'b1, 2'd2, 4'hF, 2'd2, 2'd1);
        exp_next(K_REJ, 1, "rej_in_clear"); exp_next(K_CNT, 0, "rej_cnt1");
        exp_next(K_RDA, 0, "rej_rda1"); exp_next(K_RDB, 3, "rej_rdb1");
        drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd2, 2'd1);
        exp_next(K_REJ, 0, "rej_gap"); exp_next(K_RDB, 0, "rej_zero1"); exp_next(K_RDA, 0, "rej_rda2");
        drive(1'b0, 1'b1, 2'd3, 4'hF, 2'd3, 2'd2);
        exp_next(K_REJ, 1, "rej_in_clear2"); exp_next(K_RDA, 0, "rej_rda3"); exp_next(K_CNT, 0, "rej_cnt2");
        drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd3, 2'd2);
        exp_next(K_REJ, 0, "rej_end"); exp_next(K_BUSY, 0, "rej_idle"); exp_next(K_RDA, 0, "rej_rda4");
        for (int a = 0; a < 4; a++) begin
            drive(1'b0, 1'b0, 2'd0, 4'h0, AW'(a), AW'(a));
            exp_next(K_RDA, 0, "no_stray_write");
        end

        // Reset two edges into a sweep.
        drive(1'b0, 1'b1, 2'd0, 4'h9, 2'd0, 2'd3); exp_next(K_CNT, 1, "mid_w0");
        drive(1'b0, 1'b1, 2'd3, 4'h4, 2'd0, 2'd3); exp_next(K_RDB, 4, "mid_w3");
        drive(1'b1, 1'b0, 2'd0, 4'h0, 2'd0, 2'd3); exp_next(K_BUSY, 1, "mid_busy"); exp_next(K_RDB, 4, "mid_rdb");
        drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd3); exp_next(K_RDA, 0, "mid_zero0");
        drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd3);
        @(posedge clk_2);
        #1 reset_n = 1'b0;
        exp_now(K_RDA, 0, "arst_rda"); exp_now(K_RDB, 0, "arst_rdb");
        exp_now(K_SEG, 32'h3F, "arst_seg"); exp_now(K_CNT, 0, "arst_cnt");
        exp_now(K_BUSY, 0, "arst_busy"); exp_now(K_REJ, 0, "arst_rej");
        @(negedge clk_2);
        #1 reset_n = 1'b1;
        bus.wr_en = 1'b1; bus.waddr = 2'd1; bus.wdata = 4'h6; bus.raddr_a = 2'd1; bus.raddr_b = 2'd3;
        exp_next(K_RDA, 6, "post_rst_write"); exp_next(K_CNT, 1, "post_rst_cnt");
        exp_next(K_RDB, 0, "post_rst_mem3"); exp_next(K_BUSY, 0, "post_rst_busy");

        // Counter wrap: 255 more writes take 1 -> 0.
        for (int i = 1; i <= 255; i++) begin
            drive(1'b0, 1'b1, AW'(i), DW'(i), AW'(i), 2'd0);
            if (i == 254) exp_next(K_CNT, 255, "cnt_255");
            if (i == 255) exp_next(K_CNT, 0, "cnt_wrap");
        end

        repeat (3) drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd0);
        @(negedge clk_2);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: got %0d pending expectations, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
